split_word_store: RTL and testbench

- Store-side counterpart of the load byte/halfword extractor in the MEM stage.
- Accepts SB/SH/SW requests from the pipeline and performs them on a word-wide, single-port data RAM. The RAM has no byte enables and a synchronous read.
- Sub-word stores use read-modify-write; aligned SW writes directly.
- Misaligned and illegal requests are flagged as errors and never touch memory.

---
 rtl/split_word_store_if.sv | 28 ++
 rtl/split_word_store.sv | 134 +++++++++++++
 tb/tb_split_word_store.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/split_word_store_if.sv
// Store request and word-RAM port bundle for split_word_store.
// The master side is the pipeline plus the data RAM; the slave side is the store unit.
interface split_word_store_if #(
    parameter int ADDR_WIDTH = 32
);
    logic                  req_valid;
    logic                  req_ready;
    logic [1:0]            store_type;
    logic [ADDR_WIDTH-1:0] addr;
    logic [31:0]           store_data;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic                  mem_re;
    logic [31:0]           mem_rdata;
    logic                  mem_we;
    logic [31:0]           mem_wdata;
    logic                  done;
    logic                  store_err;

    modport master (
        output req_valid, store_type, addr, store_data, mem_rdata,
        input  req_ready, mem_addr, mem_re, mem_we, mem_wdata, done, store_err
    );

    modport slave (
        input  req_valid, store_type, addr, store_data, mem_rdata,
        output req_ready, mem_addr, mem_re, mem_we, mem_wdata, done, store_err
    );
endinterface

// File: rtl/split_word_store.sv
// SB/SH/SW store unit for a word-wide RAM without byte enables.
// Sub-word stores read-modify-write; misaligned or illegal requests report an error.
module split_word_store #(
    parameter int         ADDR_WIDTH = 32,
    parameter logic [1:0] STORE_SB   = 2'd0,
    parameter logic [1:0] STORE_SH   = 2'd1,
    parameter logic [1:0] STORE_SW   = 2'd2
) (
    input logic               clk,
    input logic               rst_n,
    split_word_store_if.slave bus
);
    typedef enum logic [2:0] {IDLE, READ, MERGE, WRITE, ERR} state_t;

    state_t                state;
    logic [1:0]            type_q;
    logic [1:0]            offs_q;
    logic [31:0]           data_q;
    logic                  ready_q;
    logic                  re_q;
    logic                  we_q;
    logic                  done_q;
    logic                  err_q;
    logic [ADDR_WIDTH-1:0] maddr_q;
    logic [31:0]           wdata_q;  // doubles as the merge register

    function automatic logic is_bad(input logic [1:0] t, input logic [1:0] off);
        return (t == STORE_SH && off[0]) ||
               (t == STORE_SW && off != 2'b00) ||
               (t != STORE_SB && t != STORE_SH && t != STORE_SW);
    endfunction

    function automatic logic [31:0] merge_lane(input logic [1:0]  t,
                                               input logic [1:0]  off,
                                               input logic [31:0] old,
                                               input logic [31:0] src);
        logic [31:0] r;
        r = old;
        if (t == STORE_SB) begin
            case (off)
                2'd0:    r[7:0]   = src[7:0];
                2'd1:    r[15:8]  = src[7:0];
                2'd2:    r[23:16] = src[7:0];
                default: r[31:24] = src[7:0];
            endcase
        end else if (off[1]) begin
            r[31:16] = src[15:0];
        end else begin
            r[15:0] = src[15:0];
        end
        return r;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            type_q  <= 2'd0;
            offs_q  <= 2'd0;
            data_q  <= 32'd0;
            ready_q <= 1'b1;
            re_q    <= 1'b0;
            we_q    <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            maddr_q <= '0;
            wdata_q <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        type_q  <= bus.store_type;
                        offs_q  <= bus.addr[1:0];
                        data_q  <= bus.store_data;
                        ready_q <= 1'b0;
                        if (is_bad(bus.store_type, bus.addr[1:0])) begin
                            state  <= ERR;
                            done_q <= 1'b1;
                            err_q  <= 1'b1;
                        end else if (bus.store_type == STORE_SW) begin
                            state   <= WRITE;
                            we_q    <= 1'b1;
                            done_q  <= 1'b1;
                            maddr_q <= {bus.addr[ADDR_WIDTH-1:2], 2'b00};
                            wdata_q <= bus.store_data;
                        end else begin
                            state   <= READ;
                            re_q    <= 1'b1;
                            maddr_q <= {bus.addr[ADDR_WIDTH-1:2], 2'b00};
                        end
                    end
                end
                READ: begin
                    re_q  <= 1'b0;
                    state <= MERGE;
                end
                // RAM data for the read issued in READ is valid during this cycle.
                MERGE: begin
                    wdata_q <= merge_lane(type_q, offs_q, bus.mem_rdata, data_q);
                    we_q    <= 1'b1;
                    done_q  <= 1'b1;
                    state   <= WRITE;
                end
                WRITE: begin
                    we_q    <= 1'b0;
                    done_q  <= 1'b0;
                    ready_q <= 1'b1;
                    state   <= IDLE;
                end
                ERR: begin
                    done_q  <= 1'b0;
                    err_q   <= 1'b0;
                    ready_q <= 1'b1;
                    state   <= IDLE;
                end
                default: begin
                    re_q    <= 1'b0;
                    we_q    <= 1'b0;
                    done_q  <= 1'b0;
                    err_q   <= 1'b0;
                    ready_q <= 1'b1;
                    state   <= IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready = ready_q;
    assign bus.mem_re    = re_q;
    assign bus.mem_we    = we_q;
    assign bus.mem_addr  = maddr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.done      = done_q;
    assign bus.store_err = err_q;
endmodule

// File: tb/tb_split_word_store.sv
// Bench for split_word_store: word RAM model, per-cycle expectation queue, randomized stores.
module tb_split_word_store;
    localparam logic [1:0] SB = 2'd0, SH = 2'd1, SW = 2'd2;

    logic clk;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    int   we_cnt = 0;

    bit [31:0] ram     [0:511];
    bit [31:0] ref_mem [0:511];
    bit        pl_req;
    int        pl_idx;
    bit [31:0] pl_val;

    typedef struct {
        bit        ready;
        bit        re;
        bit        we;
        bit        done;
        bit        err;
        bit [31:0] addr;
        bit [31:0] wdata;
    } exp_t;
    exp_t exp_q[$];

    split_word_store_if #(.ADDR_WIDTH(32)) bus();

    split_word_store #(.ADDR_WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    function automatic int widx(input logic [31:0] a);
        return int'(a[10:2]);
    endfunction

    function automatic bit [31:0] ref_merge(input bit [1:0] t, input bit [31:0] a,
                                            input bit [31:0] old, input bit [31:0] d);
        int        sh;
        bit [31:0] m;
        if (t == SB) begin
            sh = 8 * int'(a[1:0]);
            m  = 32'h0000_00FF << sh;
        end else begin
            sh = 16 * int'(a[1]);
            m  = 32'h0000_FFFF << sh;
        end
        return (old & ~m) | ((d << sh) & m);
    endfunction

    function automatic bit ref_err(input bit [1:0] t, input bit [31:0] a);
        return (t == 2'd3) || (t == SH && a[0]) || (t == SW && a[1:0] != 2'b00);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h @%0t", nm, act, req, $time);
        end
    endtask

    // Word RAM with synchronous read; also takes backdoor preloads.
    always @(posedge clk) begin
        if (bus.mem_re) bus.mem_rdata <= ram[widx(bus.mem_addr)];
        if (bus.mem_we) begin
            ram[widx(bus.mem_addr)] = bus.mem_wdata;
            we_cnt++;
        end
        if (pl_req) ram[pl_idx] = pl_val;
    end

    // Model: on each accepted request, schedule the expected outputs of the following cycles.
    always @(posedge clk) begin
        bit [31:0] w;
        if (rst_n && bus.req_valid && bus.req_ready) begin
            w = {bus.addr[31:2], 2'b00};
            if (ref_err(bus.store_type, bus.addr)) begin
                exp_q.push_back('{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'd0, 32'd0});
            end else if (bus.store_type == SW) begin
                exp_q.push_back('{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, w, bus.store_data});
            end else begin
                exp_q.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, w, 32'd0});
                exp_q.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0});
                exp_q.push_back('{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, w,
                                  ref_merge(bus.store_type, bus.addr, ref_mem[widx(w)], bus.store_data)});
            end
        end
    end

    // Compare every cycle on the falling edge.
    always @(negedge clk) begin
        exp_t e;
        if (pl_req) ref_mem[pl_idx] = pl_val;
        if (!rst_n) begin
            exp_q.delete();
            chk("rst_ctl", 32'({bus.req_ready, bus.mem_re, bus.mem_we, bus.done, bus.store_err}), 32'h10);
            chk("rst_mem_addr", bus.mem_addr, 32'd0);
            chk("rst_mem_wdata", bus.mem_wdata, 32'd0);
        end else begin
            if (exp_q.size() > 0) e = exp_q.pop_front();
            else e = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0};
            chk("ctl{ready,re,we,done,err}",
                32'({bus.req_ready, bus.mem_re, bus.mem_we, bus.done, bus.store_err}),
                32'({e.ready, e.re, e.we, e.done, e.err}));
            if (e.re || e.we) chk("mem_addr", bus.mem_addr, e.addr);
            if (e.we) begin
                chk("mem_wdata", bus.mem_wdata, e.wdata);
                ref_mem[widx(e.addr)] = e.wdata;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic preload(input bit [31:0] a, input bit [31:0] v);
        pl_idx = widx(a);
        pl_val = v;
        pl_req = 1'b1;
        tick();
        pl_req = 1'b0;
    endtask

    task automatic send(input bit [1:0] t, input bit [31:0] a, input bit [31:0] d);
        bit got;
        got            = 1'b0;
        bus.store_type = t;
        bus.addr       = a;
        bus.store_data = d;
        bus.req_valid  = 1'b1;
        for (int i = 0; i < 50 && !got; i++) begin
            @(posedge clk);
            if (bus.req_ready && rst_n) got = 1'b1;
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout actual=not_accepted required=accepted addr=%h", a);
        end
        #2;
    endtask

    initial begin
        int c0;
        rst_n          = 1'b0;
        bus.req_valid  = 1'b0;
        bus.store_type = 2'd0;
        bus.addr       = 32'd0;
        bus.store_data = 32'd0;
        pl_req         = 1'b0;
        pl_idx         = 0;
        pl_val         = 32'd0;

        @(negedge clk);
        chk("reset_ready", 32'(bus.req_ready), 32'd1);
        chk("reset_we", 32'(bus.mem_we), 32'd0);
        chk("model_sb_lane2", ref_merge(SB, 32'h106, 32'h1122_3344, 32'hFFFF_FFAA), 32'h11AA_3344);
        chk("model_sh_upper", ref_merge(SH, 32'h10A, 32'hCAFE_BABE, 32'h0000_1234), 32'h1234_BABE);
        @(posedge clk);
        #2 rst_n = 1'b1;
        tick();

        // Aligned word store
        send(SW, 32'h100, 32'hDEAD_BEEF);
        bus.req_valid = 1'b0;
        @(negedge clk);
        chk("sw_we", 32'(bus.mem_we), 32'd1);
        chk("sw_re", 32'(bus.mem_re), 32'd0);
        chk("sw_done", 32'(bus.done), 32'd1);
        chk("sw_addr", bus.mem_addr, 32'h100);
        chk("sw_wdata", bus.mem_wdata, 32'hDEAD_BEEF);
        tick();

        // Byte store into lane 2
        preload(32'h104, 32'h1122_3344);
        send(SB, 32'h106, 32'hFFFF_FFAA);
        bus.req_valid = 1'b0;
        @(negedge clk);
        chk("sb_re", 32'(bus.mem_re), 32'd1);
        @(negedge clk);
        @(negedge clk);
        chk("sb_we", 32'(bus.mem_we), 32'd1);
        chk("sb_done", 32'(bus.done), 32'd1);
        chk("sb_wdata", bus.mem_wdata, 32'h11AA_3344);
        tick();

        // Halfword stores, upper then lower
        preload(32'h108, 32'hCAFE_BABE);
        send(SH, 32'h10A, 32'h0000_1234);
        bus.req_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("sh_upper_wdata", bus.mem_wdata, 32'h1234_BABE);
        tick();
        preload(32'h108, 32'hCAFE_BABE);
        send(SH, 32'h108, 32'h0000_1234);
        bus.req_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("sh_lower_wdata", bus.mem_wdata, 32'hCAFE_1234);
        tick();

        // Misaligned and illegal requests
        for (int k = 0; k < 3; k++) begin
            bit [1:0]  t;
            bit [31:0] a;
            t = (k == 0) ? SH : (k == 1) ? SW : 2'd3;
            a = (k == 0) ? 32'h101 : (k == 1) ? 32'h102 : 32'h110;
            send(t, a, 32'h5A5A_5A5A);
            bus.req_valid = 1'b0;
            @(negedge clk);
            chk("err_done_err", 32'({bus.done, bus.store_err}), 32'h3);
            chk("err_no_mem", 32'({bus.mem_we, bus.mem_re}), 32'h0);
            tick();
        end

        // Held valid, four byte stores back to back
        send(SB, 32'h200, 32'h01);
        chk("busy_ready", 32'(bus.req_ready), 32'd0);
        send(SB, 32'h201, 32'h02);
        send(SB, 32'h202, 32'h03);
        send(SB, 32'h203, 32'h04);
        bus.req_valid = 1'b0;
        repeat (6) tick();
        chk("b2b_ram", ram[widx(32'h200)], 32'h0403_0201);

        // Reset in the MERGE cycle of a byte store
        preload(32'h300, 32'h5566_7788);
        c0 = we_cnt;
        send(SB, 32'h301, 32'h99);
        bus.req_valid = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_outputs", 32'({bus.mem_we, bus.mem_re, bus.done, bus.store_err}), 32'h0);
        chk("midrst_wdata", bus.mem_wdata, 32'd0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        tick();
        chk("midrst_no_write", 32'(we_cnt - c0), 32'd0);
        chk("midrst_ram", ram[widx(32'h300)], 32'h5566_7788);
        send(SB, 32'h301, 32'h99);
        bus.req_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("postrst_done", 32'(bus.done), 32'd1);
        chk("postrst_wdata", bus.mem_wdata, 32'h5566_9988);
        tick();

        // Randomized traffic
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                bus.req_valid  = 1'b0;
                bus.store_data = $urandom;
                repeat ($urandom_range(1, 3)) tick();
            end
            send(2'($urandom_range(0, 3)), 32'h400 + $urandom_range(0, 63), $urandom);
        end
        bus.req_valid = 1'b0;
        repeat (8) tick();

        for (int i = 0; i < 512; i++) chk($sformatf("ram_word_%0d", i), ram[i], ref_mem[i]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
